// File: rtl/rv32_pkg.sv
// Shared RV32I fetch constants, the fetch FSM state type and a small decode helper.
package rv32_pkg;

  localparam logic [31:0] RV_NOP    = 32'h0000_0013;
  localparam logic [31:0] RV_EBREAK = 32'h0010_0073;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // True when the word is the EBREAK encoding.
  function automatic logic is_ebreak(input logic [31:0] instr);
    return (instr == RV_EBREAK);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id.sv
// IF/ID pipeline register: holds {valid, pc, instr} handed to the decoder.
// Flush (or reset) inserts the bubble {0, 0, RV_NOP}; load captures a new
// fetch unless hold is asserted; otherwise the contents stay put.
module if_id_register
  import rv32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic        i_hold,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  // Bubble on reset/flush, capture on load, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0;
      r_instr <= RV_NOP;
    end else if (i_load && !i_hold) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, drives imem_addr, and fills the
// IF/ID register. Handles hazard stall, EX redirect and EBREAK halt.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect
// to a non-word-aligned target enters a sticky FAULT state; when undefined the
// low two target bits are cleared and fetch_fault is tied low.
module instruction_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic        HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        halted,
  output logic        fetch_fault
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_halted;

  logic [31:0]  w_target;
  logic         w_misalign;
  logic         w_ebreak_seen;
  logic         w_load;
  logic         w_flush;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;

  // Keep the raw target so a misaligned one is visible on imem_addr in FAULT.
  assign w_target    = redirect_target;
  assign w_misalign  = |redirect_target[1:0];
  assign fetch_fault = r_fault;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (((r_state == RUN) || (r_state == HALT)) && redirect_valid && w_misalign) begin
      r_fault <= 1'b1;
    end
  end
`else
  // Without the check, targets are silently word-aligned.
  assign w_target    = redirect_target & 32'hFFFF_FFFC;
  assign w_misalign  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // An EBREAK only halts when it is a real (valid) instruction in IF/ID.
  assign w_ebreak_seen = HALT_ON_EBREAK && if_id_valid && is_ebreak(if_id_instr);

  // IF/ID control: advance only in RUN with no redirect, stall or halt;
  // any non-RUN state or a redirect squashes to a bubble.
  always_comb begin
    w_load  = 1'b0;
    w_flush = 1'b0;
    unique case (r_state)
      RUN: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
        end else if (!stall && !w_ebreak_seen) begin
          w_load = 1'b1;
        end
      end
      HALT: begin
        w_flush = 1'b1;
      end
      default: begin
        w_flush = 1'b1;
      end
    endcase
  end

  // Fetch FSM and PC: priority redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= BOOT;
      r_pc     <= RESET_VECTOR;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        BOOT: begin
          r_state <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            r_pc <= w_target;
            if (w_misalign) begin
              r_state <= FAULT;
            end
          end else if (stall) begin
            r_pc <= r_pc;
          end else if (w_ebreak_seen) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc <= r_pc + PC_STEP;
          end
        end
        HALT: begin
          if (redirect_valid) begin
            r_pc     <= w_target;
            r_halted <= 1'b0;
            r_state  <= w_misalign ? FAULT : RUN;
          end
        end
        FAULT: begin
          r_pc <= r_pc;
        end
        default: begin
          r_state <= BOOT;
        end
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign halted    = r_halted;

  // ---- IF/ID stage boundary ----
  if_id_register u_if_id (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_hold  (stall),
    .i_pc    (r_pc),
    .i_instr (imem_instr),
    .o_valid (if_id_valid),
    .o_pc    (if_id_pc),
    .o_instr (if_id_instr)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against a behavioural model of the fetch rules.
// Honours FETCH_MISALIGN_CHECK_EN to pick the expected misalignment behaviour.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        halted;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  // Instruction memory model: one EBREAK at a chosen address, otherwise an
  // address-tagged non-EBREAK word.
  logic        ebreak_en   = 1'b0;
  logic [31:0] ebreak_addr = 32'h0;

  always_comb begin
    imem_instr = (ebreak_en && (imem_addr == ebreak_addr)) ? EBREAK : {imem_addr[19:0], 12'h093};
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ebreak_en && (a == ebreak_addr)) return EBREAK;
    return {a[19:0], 12'h093};
  endfunction

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .halted          (halted),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  // Behavioural model of the fetch stage.
  int          m_mode;   // 0 boot, 1 running, 2 halted, 3 faulted
  logic [31:0] m_pc;
  logic        m_v;
  logic [31:0] m_ipc;
  logic [31:0] m_ins;
  logic        m_halted;
  logic        m_fault;

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_ins = NOP;
    m_halted = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_bubble();
    m_v = 1'b0; m_ipc = 32'h0; m_ins = NOP;
  endtask

  task automatic model_redirect(input logic [31:0] t);
    logic [1:0] lo;
    lo = t[1:0];
    model_bubble();
    m_halted = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (lo != 2'b00) begin
      m_pc = t; m_mode = 3; m_fault = 1'b1;
      return;
    end
`endif
    m_pc = t & 32'hFFFF_FFFC;
    m_mode = (lo == lo) ? 1 : 1;
  endtask

  task automatic model_step(input logic rst, input logic st, input logic rv, input logic [31:0] rt);
    if (rst) begin
      model_reset();
    end else if (m_mode == 0) begin
      model_bubble(); m_mode = 1;
    end else if (m_mode == 1) begin
      if (rv) model_redirect(rt);
      else if (st) begin end
      else if (m_v && (m_ins == EBREAK)) begin m_mode = 2; m_halted = 1'b1; end
      else begin
        m_v = 1'b1; m_ipc = m_pc; m_ins = mem_word(m_pc); m_pc = m_pc + 32'd4;
      end
    end else if (m_mode == 2) begin
      if (rv) model_redirect(rt);
      else model_bubble();
    end else begin
      model_bubble();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr actual=%h required=%h", imem_addr, 32'h0); end
    checks++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 32'h0, NOP}) begin errors++; $display("FAIL reset_ifid actual=%b/%h/%h required=0/00000000/%h", if_id_valid, if_id_pc, if_id_instr, NOP); end
    checks++; if ({halted, fetch_fault} !== 2'b00) begin errors++; $display("FAIL reset_flags actual=%b%b required=00", halted, fetch_fault); end
  endtask

  task automatic test_fetch();
    tick();
    checks++; if ({imem_addr, if_id_valid} !== {32'h0, 1'b0}) begin errors++; $display("FAIL boot_cycle actual=%h/%b required=00000000/0", imem_addr, if_id_valid); end
    tick();
    checks++; if ({imem_addr, if_id_valid, if_id_pc} !== {32'h4, 1'b1, 32'h0}) begin errors++; $display("FAIL fetch_c2 actual=%h/%b/%h required=00000004/1/00000000", imem_addr, if_id_valid, if_id_pc); end
    checks++; if (if_id_instr !== 32'h0000_0093) begin errors++; $display("FAIL fetch_instr actual=%h required=00000093", if_id_instr); end
    tick();
    checks++; if ({imem_addr, if_id_pc} !== {32'h8, 32'h4}) begin errors++; $display("FAIL fetch_c3 actual=%h/%h required=00000008/00000004", imem_addr, if_id_pc); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({imem_addr, if_id_valid, if_id_pc} !== {32'h8, 1'b1, 32'h4}) begin errors++; $display("FAIL stall_hold actual=%h/%b/%h required=00000008/1/00000004", imem_addr, if_id_valid, if_id_pc); end
    end
    stall = 1'b0;
    tick();
    checks++; if ({imem_addr, if_id_pc} !== {32'hC, 32'h8}) begin errors++; $display("FAIL stall_release actual=%h/%h required=0000000c/00000008", imem_addr, if_id_pc); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    checks++; if ({imem_addr, if_id_valid} !== {32'h40, 1'b0}) begin errors++; $display("FAIL redirect_squash actual=%h/%b required=00000040/0", imem_addr, if_id_valid); end
    tick();
    checks++; if ({if_id_valid, if_id_pc} !== {1'b1, 32'h40}) begin errors++; $display("FAIL redirect_fetch actual=%b/%h required=1/00000040", if_id_valid, if_id_pc); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h20;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    checks++; if ({imem_addr, if_id_valid, if_id_instr} !== {32'h20, 1'b0, NOP}) begin errors++; $display("FAIL stall_redirect actual=%h/%b/%h required=00000020/0/%h", imem_addr, if_id_valid, if_id_instr, NOP); end
    tick();
    checks++; if (if_id_pc !== 32'h20) begin errors++; $display("FAIL stall_redirect_next actual=%h required=00000020", if_id_pc); end
  endtask

  task automatic test_ebreak_halt();
    ebreak_en = 1'b1; ebreak_addr = 32'h10;
    redirect_valid = 1'b1; redirect_target = 32'h10;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if ({if_id_valid, if_id_instr, halted} !== {1'b1, EBREAK, 1'b0}) begin errors++; $display("FAIL ebreak_in_ifid actual=%b/%h/%b required=1/%h/0", if_id_valid, if_id_instr, halted, EBREAK); end
    tick();
    checks++; if ({halted, imem_addr} !== {1'b1, 32'h14}) begin errors++; $display("FAIL halt_enter actual=%b/%h required=1/00000014", halted, imem_addr); end
    tick(); tick();
    checks++; if ({halted, imem_addr, if_id_valid} !== {1'b1, 32'h14, 1'b0}) begin errors++; $display("FAIL halt_frozen actual=%b/%h/%b required=1/00000014/0", halted, imem_addr, if_id_valid); end
    redirect_valid = 1'b1; redirect_target = 32'h0;
    tick();
    redirect_valid = 1'b0;
    checks++; if ({halted, imem_addr, if_id_valid} !== {1'b0, 32'h0, 1'b0}) begin errors++; $display("FAIL halt_exit actual=%b/%h/%b required=0/00000000/0", halted, imem_addr, if_id_valid); end
    tick();
    checks++; if ({if_id_valid, if_id_pc, imem_addr} !== {1'b1, 32'h0, 32'h4}) begin errors++; $display("FAIL halt_resume actual=%b/%h/%h required=1/00000000/00000004", if_id_valid, if_id_pc, imem_addr); end
    ebreak_en = 1'b0;
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_target = 32'h42;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if ({fetch_fault, if_id_valid, imem_addr} !== {1'b1, 1'b0, 32'h42}) begin errors++; $display("FAIL misalign_fault actual=%b/%b/%h required=1/0/00000042", fetch_fault, if_id_valid, imem_addr); end
    tick(); tick();
    checks++; if ({fetch_fault, if_id_valid, imem_addr} !== {1'b1, 1'b0, 32'h42}) begin errors++; $display("FAIL misalign_sticky actual=%b/%b/%h required=1/0/00000042", fetch_fault, if_id_valid, imem_addr); end
`else
    checks++; if ({fetch_fault, imem_addr} !== {1'b0, 32'h40}) begin errors++; $display("FAIL misalign_align actual=%b/%h required=0/00000040", fetch_fault, imem_addr); end
    tick();
    checks++; if ({fetch_fault, if_id_valid, if_id_pc} !== {1'b0, 1'b1, 32'h40}) begin errors++; $display("FAIL misalign_fetch actual=%b/%b/%h required=0/1/00000040", fetch_fault, if_id_valid, if_id_pc); end
`endif
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_load actual=%h required=fffffffc", imem_addr); end
    tick();
    checks++; if ({imem_addr, if_id_pc, if_id_valid} !== {32'h0, 32'hFFFF_FFFC, 1'b1}) begin errors++; $display("FAIL wrap_advance actual=%h/%h/%b required=00000000/fffffffc/1", imem_addr, if_id_pc, if_id_valid); end
  endtask

  task automatic test_mid_reset();
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if ({imem_addr, if_id_valid, if_id_pc, if_id_instr, halted, fetch_fault} !== {32'h0, 1'b0, 32'h0, NOP, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset actual=%h/%b/%h/%h/%b/%b required=00000000/0/00000000/%h/0/0", imem_addr, if_id_valid, if_id_pc, if_id_instr, halted, fetch_fault, NOP);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic        r_rst, r_st, r_rv;
    logic [31:0] r_t;
    logic [98:0] exp_v, act_v;
    ebreak_en = 1'b1; ebreak_addr = 32'h30;
    apply_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 99) < 30);
      r_rv  = ($urandom_range(0, 99) < 12);
      r_t   = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) r_t[1:0] = 2'b00;
      reset = r_rst; stall = r_st; redirect_valid = r_rv; redirect_target = r_t;
      model_step(r_rst, r_st, r_rv, r_t);
      tick();
      exp_v = {m_pc, m_v, m_ipc, m_ins, m_halted, m_fault};
      act_v = {imem_addr, if_id_valid, if_id_pc, if_id_instr, halted, fetch_fault};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d actual=%h/%b/%h/%h/%b/%b required=%h/%b/%h/%h/%b/%b", i,
                 imem_addr, if_id_valid, if_id_pc, if_id_instr, halted, fetch_fault,
                 m_pc, m_v, m_ipc, m_ins, m_halted, m_fault);
      end
    end
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    ebreak_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_ebreak_halt();
    test_misaligned();
    test_pc_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
